// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Bus-target timer: 32-bit up-counter with 8-bit prescaler,
//               compare register, sticky match flag and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bSel,
    input  logic [31:0] bAddr,
    input  logic [31:0] bWData,
    input  logic        bWrite,
    input  logic [1:0]  mem_size,
    output logic [31:0] bRData,
    output logic        irq
);

    localparam logic [1:0] c_REG_CTRL    = 2'd0;
    localparam logic [1:0] c_REG_COUNT   = 2'd1;
    localparam logic [1:0] c_REG_COMPARE = 2'd2;
    localparam logic [1:0] c_REG_STATUS  = 2'd3;

    logic        r_en;
    logic        r_autoreload;
    logic        r_ie;
    logic [7:0]  r_presc;
    logic [7:0]  r_pcnt;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;

    logic        w_wr;
    logic [3:0]  w_be;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_unused_addr = ^bAddr[31:4];

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[k*8 +: 8] = be[k] ? new_val[k*8 +: 8] : old_val[k*8 +: 8];
        end
        return res;
    endfunction

    assign w_wr = bSel & bWrite;

    // Halfword writes align to bAddr[1]; bAddr[0] is ignored for them.
    always_comb begin
        w_be = 4'b0000;
        if (w_wr) begin
            case (mem_size)
                2'b00:   w_be = 4'b0001 << bAddr[1:0];
                2'b01:   w_be = bAddr[1] ? 4'b1100 : 4'b0011;
                default: w_be = 4'b1111;
            endcase
        end
    end

    assign w_wr_ctrl    = w_wr & (bAddr[3:2] == c_REG_CTRL);
    assign w_wr_count   = w_wr & (bAddr[3:2] == c_REG_COUNT);
    assign w_wr_compare = w_wr & (bAddr[3:2] == c_REG_COMPARE);
    assign w_wr_status  = w_wr & (bAddr[3:2] == c_REG_STATUS);

    assign w_tick = r_en & (r_pcnt == r_presc);
    assign w_hit  = w_tick & (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt <= 8'h00;
        end else if (w_wr_ctrl || !r_en || w_tick) begin
            r_pcnt <= 8'h00;
        end else begin
            r_pcnt <= r_pcnt + 8'h01;
        end
    end

    // A bus write to COUNT takes precedence over the tick update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 32'h0;
        end else if (w_wr_count) begin
            r_count <= merge_lanes(r_count, bWData, w_be);
        end else if (w_tick) begin
            if (!w_hit) begin
                r_count <= r_count + 32'h1;
            end else if (r_autoreload) begin
                r_count <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_compare <= COMPARE_RST;
        end else if (w_wr_compare) begin
            r_compare <= merge_lanes(r_compare, bWData, w_be);
        end
    end

    // Software writing the low CTRL byte beats the one-shot enable clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_ie         <= 1'b0;
            r_presc      <= 8'h00;
        end else begin
            if (w_wr_ctrl && w_be[0]) begin
                r_en         <= bWData[0];
                r_autoreload <= bWData[1];
                r_ie         <= bWData[2];
            end else if (w_hit && !r_autoreload) begin
                r_en <= 1'b0;
            end
            if (w_wr_ctrl && w_be[1]) begin
                r_presc <= bWData[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status && w_be[0] && bWData[0]) begin
            r_match <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (bSel && !bWrite) begin
            case (bAddr[3:2])
                c_REG_CTRL:    w_rdata = {16'h0, r_presc, 5'h0, r_ie, r_autoreload, r_en};
                c_REG_COUNT:   w_rdata = r_count;
                c_REG_COMPARE: w_rdata = r_compare;
                c_REG_STATUS:  w_rdata = {31'h0, r_match};
                default:       w_rdata = 32'h0;
            endcase
        end
    end

    assign bRData = w_rdata;
    assign irq    = r_match & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Self-checking bench for bus_timer against a register-level
//               reference model, with directed and randomized bus traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bSel;
    logic [31:0] bAddr;
    logic [31:0] bWData;
    logic        bWrite;
    logic [1:0]  mem_size;
    logic [31:0] bRData;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: CTRL kept as its architectural read word.
    logic [31:0] m_ctrl;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_match;
    int          m_pcnt;
    logic        m_valid = 1'b0;

    bus_timer #(.COMPARE_RST(32'hFFFF_FFFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bSel     (bSel),
        .bAddr    (bAddr),
        .bWData   (bWData),
        .bWrite   (bWrite),
        .mem_size (mem_size),
        .bRData   (bRData),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        int size;
        int base;
        logic [3:0] m;
        size = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = (int'(a) / size) * size;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) m[i] = (i >= base) && (i < base + size);
        return m;
    endfunction

    function automatic logic [31:0] overlay(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read();
        if (!(bSel && !bWrite)) return 32'h0;
        case (bAddr[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return {31'h0, m_match};
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        logic [3:0]  lanes;
        logic [1:0]  idx;
        logic        wr, en, tick, hit;
        logic [31:0] n_ctrl, n_count, n_compare;
        logic        n_match;
        int          n_pcnt;
        if (!rst_n) begin
            m_ctrl    <= 32'h0;
            m_count   <= 32'h0;
            m_compare <= 32'hFFFF_FFFF;
            m_match   <= 1'b0;
            m_pcnt    <= 0;
            m_valid   <= 1'b1;
        end else begin
            wr    = bSel && bWrite;
            idx   = bAddr[3:2];
            lanes = lane_mask(mem_size, bAddr[1:0]);
            en    = m_ctrl[0];
            tick  = en && (m_pcnt == int'(m_ctrl[15:8]));
            hit   = tick && (m_count == m_compare);
            n_ctrl = m_ctrl; n_count = m_count; n_compare = m_compare; n_match = m_match;
            n_pcnt = ((wr && idx == 2'd0) || !en || tick) ? 0 : m_pcnt + 1;
            if (tick) begin
                if (hit) begin
                    if (m_ctrl[1]) n_count = 32'h0;
                    else           n_ctrl[0] = 1'b0;
                end else begin
                    n_count = m_count + 32'h1;
                end
            end
            if (wr) begin
                case (idx)
                    2'd0: n_ctrl    = overlay(n_ctrl, bWData, lanes) & 32'h0000_FF07;
                    2'd1: n_count   = overlay(m_count, bWData, lanes);
                    2'd2: n_compare = overlay(m_compare, bWData, lanes);
                    default: if (lanes[0] && bWData[0]) n_match = 1'b0;
                endcase
            end
            if (hit) n_match = 1'b1;
            m_ctrl <= n_ctrl; m_count <= n_count; m_compare <= n_compare;
            m_match <= n_match; m_pcnt <= n_pcnt;
        end
    end

    // Cycle-by-cycle comparison of the bus-visible outputs.
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (bRData !== m_read()) begin
                n_fail++;
                $display("FAIL model_rdata t=%0t addr=%h got %h expected %h", $time, bAddr, bRData, m_read());
            end
            n_checks++;
            if (irq !== (m_match & m_ctrl[2])) begin
                n_fail++;
                $display("FAIL model_irq t=%0t got %b expected %b", $time, irq, m_match & m_ctrl[2]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] sz);
        @(posedge clk);
        #1;
        bSel = sel; bWrite = wr; bAddr = addr; bWData = data; mem_size = sz;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b1, addr, data, 2'b10);
    endtask

    task automatic rd(input logic [31:0] addr);
        drive(1'b1, 1'b0, addr, 32'h0, 2'b10);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        rd(addr);
        @(negedge clk);
        #1;
        check(name, bRData, exp);
        check({name, "_model"}, m_read(), exp);
    endtask

    initial begin
        logic [31:0] r32;
        logic [31:0] data;
        logic [31:0] addr;
        rst_n = 1'b0; bSel = 1'b0; bWrite = 1'b0; bAddr = 32'h0; bWData = 32'h0; mem_size = 2'b10;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk); #1;
        check("reset_idle_rdata", bRData, 32'h0);
        rd_check("reset_ctrl", 32'h0, 32'h0);
        rd_check("reset_count", 32'h4, 32'h0);
        rd_check("reset_compare", 32'h8, 32'hFFFF_FFFF);
        rd_check("reset_status", 32'hC, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // Byte and halfword lanes
        wr32(32'h8, 32'h1122_3344);
        drive(1'b1, 1'b1, 32'hA, 32'h00AA_0000, 2'b00);
        rd_check("byte_lane", 32'h8, 32'h11AA_3344);
        drive(1'b1, 1'b1, 32'h8, 32'h0000_BEEF, 2'b01);
        rd_check("half_lane", 32'h8, 32'h11AA_BEEF);

        // Autoreload with presc = 1
        wr32(32'h8, 32'd3);
        wr32(32'h4, 32'd0);
        wr32(32'h0, 32'h0000_0107);
        for (int k = 0; k < 9; k++) begin
            rd(32'h4);
            @(negedge clk); #1;
            check($sformatf("autoreload_count_k%0d", k), bRData, (k < 8) ? k / 2 : 0);
            check($sformatf("autoreload_irq_k%0d", k), {31'h0, irq}, (k >= 8) ? 32'h1 : 32'h0);
        end
        wr32(32'hC, 32'h1);
        rd_check("w1c_status", 32'hC, 32'h0);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        wr32(32'h0, 32'h0);

        // One-shot
        wr32(32'h4, 32'd0);
        wr32(32'h8, 32'd2);
        wr32(32'hC, 32'h1);
        wr32(32'h0, 32'h0000_0001);
        for (int k = 0; k < 14; k++) begin
            rd(32'h4);
            @(negedge clk); #1;
            check($sformatf("oneshot_count_k%0d", k), bRData, (k < 2) ? k : 2);
        end
        rd_check("oneshot_ctrl", 32'h0, 32'h0);
        rd_check("oneshot_match", 32'hC, 32'h1);

        // Match tick collides with W1C
        wr32(32'h4, 32'd0);
        wr32(32'h8, 32'd0);
        wr32(32'hC, 32'h1);
        wr32(32'h0, 32'h0000_0003);
        wr32(32'hC, 32'h1);
        rd_check("w1c_vs_match", 32'hC, 32'h1);
        wr32(32'h0, 32'h0);

        // COUNT write on a tick cycle
        wr32(32'h8, 32'hFFFF_FFFF);
        wr32(32'h4, 32'd0);
        wr32(32'h0, 32'h0000_0001);
        wr32(32'h4, 32'd100);
        rd_check("count_write_vs_tick", 32'h4, 32'd100);
        wr32(32'h0, 32'h0);

        // Wrap without match
        wr32(32'hC, 32'h1);
        wr32(32'h4, 32'hFFFF_FFFF);
        wr32(32'h8, 32'd5);
        wr32(32'h0, 32'h0000_0001);
        rd_check("wrap_before", 32'h4, 32'hFFFF_FFFF);
        rd_check("wrap_after", 32'h4, 32'h0);
        rd_check("wrap_no_match", 32'hC, 32'h0);
        wr32(32'h0, 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            addr = $urandom;
            data = $urandom;
            case (addr[3:2])
                2'd0: begin
                    r32 = $urandom_range(0, 3);
                    data[15:8] = r32[7:0];
                    data[0] = ($urandom_range(0, 3) != 0);
                end
                2'd1: data = ($urandom_range(0, 9) == 0) ? data : $urandom_range(0, 8);
                2'd2: data = $urandom_range(0, 12);
                default: ;
            endcase
            r32 = $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, addr, data, r32[1:0]);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_timer.md
# bus_timer

Memory-mapped timer/counter peripheral that responds on the SoC data bus as a target. It sits behind the bus address decoder on one select line and returns read data to the bus read-data mux. It holds a 32-bit up-counter with an 8-bit prescaler, a compare register, a sticky match flag and a level interrupt output. Bus writes use byte, halfword or word lanes.

## Interface
- COMPARE_RST, 32'hFFFF_FFFF, reset value of COMPARE
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- bSel  in  1  this target's decoded select from the bus decoder
- bAddr  in  32  byte address; only [3:0] used, [31:4] ignored
- bWData  in  32  write data, lane-aligned (byte k on bits 8k+7:8k)
- bWrite  in  1  1 = write, 0 = read
- mem_size  in  2  00 byte, 01 halfword, 10/11 word
- bRData  out  32  read data to the bus mux
- irq  out  1  level interrupt = STATUS.match & CTRL.ie

## Operation
- Register map, selected by bAddr[3:2]:
  - 0x0 CTRL: bit0 en, bit1 autoreload, bit2 ie, bits15:8 presc; other bits read 0
  - 0x4 COUNT: 32-bit counter, R/W
  - 0x8 COMPARE: 32-bit, R/W
  - 0xC STATUS: bit0 match, write-1-to-clear; other bits read 0, writes ignored
- Write strobes, active when bSel & bWrite:
  - Byte: lane bAddr[1:0]
  - Halfword: lanes {bAddr[1],0} and {bAddr[1],1}; bAddr[0] ignored
  - Word: all four lanes
  - Unstrobed lanes keep their value
- Read is combinational: bRData = selected register when bSel & ~bWrite, else 32'h0. mem_size is ignored on reads; the full word is returned. Reads have no side effects.
- Prescaler: 8-bit pcnt runs only while en = 1.
  - When pcnt == presc: tick = 1 and pcnt <= 0. Otherwise pcnt <= pcnt + 1.
  - One tick every presc+1 cycles.
  - pcnt <= 0 on any CTRL write and whenever en = 0.
- On tick:
  - If COUNT == COMPARE: match <= 1.
    - autoreload = 1: COUNT <= 0.
    - autoreload = 0: COUNT holds and en <= 0 (one-shot).
  - Else COUNT <= COUNT + 1, wrapping mod 2^32. Wrap sets no flag.
- Simultaneous events, in priority order:
  - Bus write to COUNT overrides tick update of COUNT that cycle. Compare uses the pre-write COUNT.
  - Hardware match set beats STATUS W1C in the same cycle; match ends at 1.
  - Bus write to CTRL overrides hardware en clear from a one-shot match.

## Timing
- Reset (rst_n = 0 at a clk edge) gives: CTRL = 0, COUNT = 0, COMPARE = COMPARE_RST, match = 0, pcnt = 0. So irq = 0 and bRData = 0 with bSel low.
- Reset mid-count wins over every bus write and tick in that cycle.
- Writes: data is visible on bRData the cycle after the write edge.
- Reads: zero wait states; valid in the same cycle bSel/bAddr are stable.
- With presc = 0 and en = 1: COUNT increments every cycle, starting the first edge after en is written.
- Match on COMPARE = N from COUNT = 0 occurs at the (N+1)th tick.
  - match and irq are high the cycle after that tick edge.
  - irq = match & ie, combinational from registers, no extra latency.

## Test plan
- Reset values:
  - Assert rst_n = 0 for 2 cycles then release.
  - Read 0x0/0x4/0x8/0xC: returns 0, 0, 32'hFFFF_FFFF, 0; irq = 0.
- Byte lanes:
  - Word-write 0x8 = 32'h1122_3344, then byte-write 0xAA at address 0xA.
  - Read 0x8 = 32'h11AA_3344.
  - Halfword-write 0xBEEF at address 0x8; read 0x8 = 32'h11AA_BEEF.
- Autoreload with prescaler:
  - Set COMPARE = 3, CTRL = {presc = 1, ie, autoreload, en}.
  - COUNT steps 0,1,2,3 every 2 cycles, then returns to 0.
  - match and irq rise after the 4th tick.
  - W1C of STATUS drops irq next cycle.
- One-shot:
  - Set COMPARE = 2, presc = 0, autoreload = 0, en = 1.
  - COUNT stops at 2, CTRL.en reads 0, match = 1, COUNT stays 2 for 10 further cycles.
- Collisions:
  - Write 1 to STATUS in the same cycle as a match tick: match reads 1.
  - Write COUNT = 100 on a tick cycle: COUNT reads 100 next cycle.
  - Preload COUNT = 32'hFFFF_FFFF with COMPARE = 5: COUNT wraps to 0 with no match.
